led_status_ctrl: RTL and testbench

//   Parametrised multi-channel status-LED driver for bootloader board tops; replaces the fixed free-running
//   LED counter. Each channel independently selects OFF / ON / BLINK / BREATHE / ACTIVITY. Shared ms-tick

---
 rtl/led_status_ctrl.sv | 142 ++++++++++++++
 tb/tb_led_status_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/led_status_ctrl.sv
// Multi-channel status-LED driver: per-channel OFF/ON/BLINK/BREATHE/ACTIVITY
// over a shared ms-tick prescaler, blink phase and breathe ramp.
module led_status_ctrl #(
  parameter int NUM_LEDS         = 1,
  parameter int TICK_DIV         = 48000,
  parameter int BLINK_HALF_TICKS = 256,
  parameter int ACT_TICKS        = 50,
  parameter int PWM_BITS         = 8,
  parameter int ACTIVE_LOW       = 0
) (
  input  logic                    clk_48mhz,
  input  logic                    reset,
  input  logic                    resync,
  input  logic [3*NUM_LEDS-1:0]   mode,
  input  logic [NUM_LEDS-1:0]     act_strobe,
  output logic [NUM_LEDS-1:0]     led,
  output logic                    tick
);

  localparam int PRESC_W = $clog2(TICK_DIV);
  localparam int BLINK_W = (BLINK_HALF_TICKS > 1) ? $clog2(BLINK_HALF_TICKS) : 1;
  localparam int ACT_W   = $clog2(ACT_TICKS + 1);

  localparam logic [PRESC_W-1:0]  PRESC_MAX = PRESC_W'(TICK_DIV - 1);
  localparam logic [BLINK_W-1:0]  BLINK_MAX = BLINK_W'(BLINK_HALF_TICKS - 1);
  localparam logic [ACT_W-1:0]    ACT_LOAD  = ACT_W'(ACT_TICKS);
  localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;
  localparam logic                POL       = (ACTIVE_LOW != 0);

  localparam logic [2:0] MODE_OFF      = 3'd0;
  localparam logic [2:0] MODE_ON       = 3'd1;
  localparam logic [2:0] MODE_BLINK    = 3'd2;
  localparam logic [2:0] MODE_BREATHE  = 3'd3;
  localparam logic [2:0] MODE_ACTIVITY = 3'd4;

  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic                tick_q, tick_d;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic                ramp_down_q, ramp_down_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [ACT_W-1:0]    act_cnt_q [NUM_LEDS];
  logic [ACT_W-1:0]    act_cnt_d [NUM_LEDS];
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic [NUM_LEDS-1:0] lit;

  always_comb begin
    presc_d       = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
    tick_d        = (presc_q == PRESC_MAX);
    pwm_cnt_d     = pwm_cnt_q + 1'b1;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    level_d       = level_q;
    ramp_down_d   = ramp_down_q;

    if (tick_q) begin
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end

      // Turning at the endpoints immediately holds each extreme for exactly one tick.
      if (!ramp_down_q) begin
        if (level_q == LEVEL_MAX) begin
          level_d     = level_q - 1'b1;
          ramp_down_d = 1'b1;
        end else begin
          level_d = level_q + 1'b1;
        end
      end else begin
        if (level_q == '0) begin
          level_d     = PWM_BITS'(1);
          ramp_down_d = 1'b0;
        end else begin
          level_d = level_q - 1'b1;
        end
      end
    end

    if (resync) begin
      presc_d       = '0;
      tick_d        = 1'b0;
      pwm_cnt_d     = '0;
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
      level_d       = '0;
      ramp_down_d   = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      act_cnt_d[i] = act_cnt_q[i];
      if (act_strobe[i]) begin
        act_cnt_d[i] = ACT_LOAD;
      end else if (tick_q && (act_cnt_q[i] != '0)) begin
        act_cnt_d[i] = act_cnt_q[i] - 1'b1;
      end

      case (mode[3*i +: 3])
        MODE_OFF:      lit[i] = 1'b0;
        MODE_ON:       lit[i] = 1'b1;
        MODE_BLINK:    lit[i] = blink_phase_q;
        MODE_BREATHE:  lit[i] = (pwm_cnt_q < level_q);
        MODE_ACTIVITY: lit[i] = (act_cnt_q[i] != '0);
        default:       lit[i] = 1'b0;
      endcase
      led_d[i] = lit[i] ^ POL;
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      presc_q       <= '0;
      tick_q        <= 1'b0;
      pwm_cnt_q     <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      level_q       <= '0;
      ramp_down_q   <= 1'b0;
      led_q         <= {NUM_LEDS{POL}};
      for (int i = 0; i < NUM_LEDS; i++) act_cnt_q[i] <= '0;
    end else begin
      presc_q       <= presc_d;
      tick_q        <= tick_d;
      pwm_cnt_q     <= pwm_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      level_q       <= level_d;
      ramp_down_q   <= ramp_down_d;
      led_q         <= led_d;
      for (int i = 0; i < NUM_LEDS; i++) act_cnt_q[i] <= act_cnt_d[i];
    end
  end

  assign led  = led_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Directed bench for led_status_ctrl: active-high and active-low builds side by side,
// checked against hand-computed vectors and a timing model built from closed-form formulas.
module tb_led_status_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       resync = 1'b0;
  logic [5:0] mode = {3'd1, 3'd1};
  logic [1:0] act_strobe = 2'b00;
  logic [1:0] led, led_al;
  logic       tick, tick_al;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_status_ctrl #(.NUM_LEDS(2), .TICK_DIV(4), .BLINK_HALF_TICKS(3), .ACT_TICKS(2),
                    .PWM_BITS(3), .ACTIVE_LOW(0)) dut (
    .clk_48mhz(clk), .reset(reset), .resync(resync), .mode(mode),
    .act_strobe(act_strobe), .led(led), .tick(tick));

  led_status_ctrl #(.NUM_LEDS(2), .TICK_DIV(4), .BLINK_HALF_TICKS(3), .ACT_TICKS(2),
                    .PWM_BITS(3), .ACTIVE_LOW(1)) dut_al (
    .clk_48mhz(clk), .reset(reset), .resync(resync), .mode(mode),
    .act_strobe(act_strobe), .led(led_al), .tick(tick_al));

  // n = clock edges since the last reset/resync; every shared timer is a function of n.
  int         n;
  int         act_m [2];
  logic [1:0] led_m;

  function automatic int ticks_done(int m);
    return (m <= 0) ? 0 : (m - 1) / 4;
  endfunction

  function automatic logic tick_of(int m);
    return (m > 0) && (m % 4 == 0);
  endfunction

  function automatic int tri_lvl(int t);
    int p;
    p = t % 14;
    return (p <= 7) ? p : 14 - p;
  endfunction

  function automatic logic lit_of(int md, int m, int act);
    case (md)
      1:       return 1'b1;
      2:       return ((ticks_done(m) / 3) % 2) == 1;
      3:       return (m % 8) < tri_lvl(ticks_done(m));
      4:       return act != 0;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      n     <= 0;
      led_m <= 2'b00;
      for (int i = 0; i < 2; i++) act_m[i] <= 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        led_m[i] <= lit_of(int'(mode[3*i +: 3]), n, act_m[i]);
        if (act_strobe[i]) act_m[i] <= 2;
        else if (tick_of(n) && act_m[i] != 0) act_m[i] <= act_m[i] - 1;
      end
      n <= resync ? 0 : n + 1;
    end
  end

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (n=%0d)", tag, obs, exp, n);
    end
  endtask

  task automatic step(input int k, input string tag);
    repeat (k) begin
      @(negedge clk);
      chk({tag, "_led"}, led, led_m);
      chk({tag, "_led_al"}, led_al, ~led_m);
      chk({tag, "_tick"}, {1'b0, tick}, {1'b0, tick_of(n)});
      chk({tag, "_tick_al"}, {1'b0, tick_al}, {1'b0, tick_of(n)});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // reset held 3 cycles with both channels ON
    repeat (3) begin
      @(negedge clk);
      chk("rst_led", led, 2'b00);
      chk("rst_led_al", led_al, 2'b11);
      chk("rst_tick", {1'b0, tick}, 2'b00);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("on_led", led, 2'b11);
    chk("on_led_al", led_al, 2'b00);
    step(6, "on");

    // blink from a fresh resync: low 13 edges (first half includes the restart edge), then 12/12
    mode = {3'd2, 3'd2};
    resync = 1'b1;
    @(negedge clk);
    resync = 1'b0;
    for (int k = 1; k <= 37; k++) begin
      @(negedge clk);
      chk("blink_led", led, (k >= 14 && k <= 25) ? 2'b11 : 2'b00);
      chk("blink_led_al", led_al, (k >= 14 && k <= 25) ? 2'b00 : 2'b11);
      chk("blink_tick", {1'b0, tick}, {1'b0, (k % 4 == 0)});
    end

    // resync mid-blink with phase high, 5 ticks in; ch1 activity count survives
    resync = 1'b1;
    @(negedge clk);
    resync = 1'b0;
    step(21, "blink2");
    chk("midblink_phase", led, 2'b11);
    mode = {3'd4, 3'd2};
    act_strobe = 2'b10;
    step(1, "pre_resync");
    act_strobe = 2'b00;
    resync = 1'b1;
    @(negedge clk);
    chk("resync_tick", {1'b0, tick}, 2'b00);
    chk("resync_led", led, 2'b11);
    resync = 1'b0;
    @(negedge clk);
    chk("post_resync_led", led, 2'b10);
    step(20, "post_resync");

    // activity ch0: single strobe, then a strobe coincident with a tick
    mode = {3'd0, 3'd4};
    act_strobe = 2'b01;
    @(negedge clk);
    act_strobe = 2'b00;
    @(negedge clk);
    chk("act_lit", led, 2'b01);
    step(14, "act1");
    begin
      bit found = 0;
      for (int k = 0; k < 8 && !found; k++) begin
        step(1, "act_wait");
        if (tick) found = 1;
      end
      chk("act_tick_seen", {1'b0, found}, 2'b01);
    end
    act_strobe = 2'b01;
    step(1, "act_coincide");
    act_strobe = 2'b00;
    step(16, "act2");

    // breathe over two full triangle periods
    mode = {3'd3, 3'd3};
    resync = 1'b1;
    @(negedge clk);
    resync = 1'b0;
    step(5, "breathe_lo");
    chk("breathe_zero", led, 2'b00);
    step(120, "breathe");

    // reserved modes are unlit
    for (int m = 5; m <= 7; m++) begin
      mode = {m[2:0], m[2:0]};
      step(1, "reserved_lag");
      @(negedge clk);
      chk("reserved_led", led, 2'b00);
      step(3, "reserved");
    end

    // consecutive mode changes 2 -> 1 -> 0 follow with one cycle lag
    mode = {3'd2, 3'd2};
    step(1, "tog_blink");
    mode = {3'd1, 3'd1};
    @(negedge clk);
    chk("tog_on", led, 2'b11);
    mode = {3'd0, 3'd0};
    @(negedge clk);
    chk("tog_off", led, 2'b00);
    step(2, "tog");

    // reset dominates resync
    mode = {3'd1, 3'd1};
    reset = 1'b1;
    resync = 1'b1;
    @(negedge clk);
    chk("rst_rsync_led", led, 2'b00);
    chk("rst_rsync_led_al", led_al, 2'b11);
    chk("rst_rsync_tick", {1'b0, tick}, 2'b00);
    reset = 1'b0;
    resync = 1'b0;
    @(negedge clk);
    chk("rst_rsync_on", led, 2'b11);
    step(8, "final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
